// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// bubble-inserting flush and a saturating count of empty output cycles.
module pipe_stage_skid #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 64,
  parameter int NUM_DATA = 3,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int DW = NUM_DATA * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DW-1:0]     main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DW-1:0]     skid_data;

  logic accept;
  logic release_main;
  logic main_free;

  // in_ready looks only at the skid slot and flush, never at out_ready,
  // so no combinational path runs from downstream back to upstream.
  assign in_ready     = !skid_valid && !flush;
  assign accept       = in_valid && in_ready;
  assign release_main = main_valid && out_ready;
  assign main_free    = !main_valid || release_main;

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else begin
      // SKID is always older than any new input, so it refills MAIN first.
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_ctrl  <= skid_ctrl;
        end else begin
          main_valid <= accept;
          if (accept) main_ctrl <= in_ctrl;
        end
      end
      if (accept && !main_free) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= in_ctrl;
      end else if (main_free && skid_valid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // Data follows the same moves as ctrl but is left untouched by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (!flush) begin
      if (main_free && skid_valid)  main_data <= skid_data;
      else if (main_free && accept) main_data <= in_data;
      if (accept && !main_free)     skid_data <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!main_valid && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed steps plus a seeded random
// run, checked against an occupancy model and an in-order scoreboard.
module tb_pipe_stage_skid;

  localparam int CTRL_W   = 8;
  localparam int DATA_W   = 64;
  localparam int NUM_DATA = 3;
  localparam int DW       = NUM_DATA * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DW-1:0]     in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
  logic [15:0]       bubble_cnt;

  logic              sm_in_ready;
  logic              sm_out_valid;
  logic [CTRL_W-1:0] sm_out_ctrl;
  logic [DW-1:0]     sm_out_data;
  logic [3:0]        sm_bubble_cnt;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
  } entry_t;

  entry_t sb[$];
  int errors = 0;
  int checks = 0;
  int exp_bub = 0;
  int exp_sm  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .bubble_cnt(bubble_cnt)
  );

  // Idle copy with a narrow counter to exercise saturation quickly.
  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CNT_W(4)) dut_cnt (
    .clk(clk), .reset(reset), .in_valid(1'b0), .in_ready(sm_in_ready),
    .in_ctrl('0), .in_data('0), .flush(1'b0), .out_valid(sm_out_valid),
    .out_ready(1'b0), .out_ctrl(sm_out_ctrl), .out_data(sm_out_data), .bubble_cnt(sm_bubble_cnt)
  );

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle against the model, then
  // advance the model by what the handshake should have done at the edge.
  task automatic apply_stimulus(input logic iv, input logic [CTRL_W-1:0] c,
                                input logic [DW-1:0] d, input logic ordy, input logic fl);
    logic exp_rdy;
    logic acc;
    logic rel;
    entry_t head;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #3;
    exp_rdy = !fl && (sb.size() < 2);
    check_output("in_ready", DW'(in_ready), DW'(exp_rdy));
    check_output("out_valid", DW'(out_valid), DW'(sb.size() > 0));
    if (sb.size() > 0) begin
      head = sb[0];
      check_output("out_ctrl", DW'(out_ctrl), DW'(head.ctrl));
      check_output("out_data", out_data, head.data);
    end else begin
      check_output("bubble_ctrl", DW'(out_ctrl), '0);
    end
    check_output("bubble_cnt", DW'(bubble_cnt), DW'(exp_bub));
    check_output("sm_bubble_cnt", DW'(sm_bubble_cnt), DW'(exp_sm));
    rel = (sb.size() > 0) && ordy;
    acc = iv && exp_rdy;
    if (sb.size() == 0 && exp_bub < 65535) exp_bub++;
    if (exp_sm < 15) exp_sm++;
    if (fl) begin
      sb.delete();
    end else begin
      if (rel) void'(sb.pop_front());
      if (acc) sb.push_back('{c, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic iv);
    reset     = 1'b1;
    in_valid  = iv;
    in_ctrl   = 8'h3C;
    in_data   = rnd_data();
    out_ready = 1'b1;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_bub = 0;
    exp_sm  = 0;
    check_output("rst_out_valid", DW'(out_valid), '0);
    check_output("rst_out_ctrl", DW'(out_ctrl), '0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_in_ready", DW'(in_ready), DW'(1'b1));
    check_output("rst_bubble_cnt", DW'(bubble_cnt), '0);
  endtask

  initial begin
    void'($urandom(32'd1234));
    @(posedge clk);
    #1;
    do_reset(1'b0);

    $display("[TB] idle counter saturation");
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    check_output("sm_bubble_sat", DW'(sm_bubble_cnt), DW'(4'd15));
    check_output("bubble_20", DW'(bubble_cnt), DW'(16'd20));

    $display("[TB] single entry then stream");
    apply_stimulus(1'b1, 8'hA5, DW'(64'h1), 1'b1, 1'b0);
    check_output("first_ctrl", DW'(out_ctrl), DW'(8'hA5));
    check_output("first_lane0", DW'(out_data[63:0]), DW'(64'h1));
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, CTRL_W'(8'h10 + i), rnd_data(), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] back-pressure fills skid");
    apply_stimulus(1'b1, 8'hE0, rnd_data(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hE1, rnd_data(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hE2, rnd_data(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hE3, rnd_data(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] flush with both entries full");
    apply_stimulus(1'b1, 8'hF0, rnd_data(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hF1, rnd_data(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hEE, rnd_data(), 1'b1, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, CTRL_W'(8'h40 + i), rnd_data(), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] toggling out_ready");
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, CTRL_W'(8'h60 + i), rnd_data(), i[0], 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1000; i++)
      apply_stimulus(1'($urandom_range(0, 1)), CTRL_W'($urandom()), rnd_data(),
                     1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] reset while skid full");
    apply_stimulus(1'b1, 8'hB0, rnd_data(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hB1, rnd_data(), 1'b0, 1'b0);
    do_reset(1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
